// File: rtl/osc_clk_div_if.sv
// Control/status bundle between fabric logic and the oscillator clock divider.
interface osc_clk_div_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] div;
  logic             req;
  logic             ack;
  logic             clko;
  logic             ce;
  logic             running;

  modport master (
    output en, div, req,
    input  ack, clko, ce, running
  );

  modport slave (
    input  en, div, req,
    output ack, clko, ce, running
  );
endinterface

// File: rtl/osc_clk_div.sv
// Programmable divider for the oscillator clock: registered CLKO, one-cycle CE strobe,
// and run-time ratio changes that only take effect at period boundaries.
module osc_clk_div #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEF_DIV = 4
) (
  input logic          i_clki,
  input logic          i_rstn,
  osc_clk_div_if.slave bus
);

  localparam logic [1:0] ST_STOPPED = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PEND    = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_pend;
  logic             r_req_d;
  logic             r_ack;
  logic             r_clko;
  logic             r_ce;
  logic             r_running;

  logic             w_cap;
  logic [WIDTH-1:0] w_cap_val;
  logic             w_wrap;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_half;

  assign w_cap     = bus.req & ~r_req_d;
  assign w_cap_val = (bus.div < WIDTH'(2)) ? WIDTH'(2) : bus.div;
  assign w_wrap    = (r_cnt == (r_n - WIDTH'(1)));
  assign w_cnt_nxt = w_wrap ? '0 : (r_cnt + WIDTH'(1));
  assign w_half    = r_n - (r_n >> 1);

  always_ff @(posedge i_clki or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state   <= ST_STOPPED;
      r_cnt     <= '0;
      r_n       <= WIDTH'(DEF_DIV);
      r_pend    <= WIDTH'(DEF_DIV);
      r_req_d   <= 1'b0;
      r_ack     <= 1'b0;
      r_clko    <= 1'b0;
      r_ce      <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_req_d <= bus.req;
      r_ack   <= 1'b0;
      r_ce    <= 1'b0;
      if (w_cap) r_pend <= w_cap_val;

      case (r_state)
        ST_STOPPED: begin
          r_cnt  <= '0;
          r_clko <= 1'b0;
          if (w_cap) begin
            r_n   <= w_cap_val;
            r_ack <= 1'b1;
          end
          // First period starts on the enabling edge, so CLKO rises immediately.
          if (bus.en) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
            r_clko    <= 1'b1;
          end
        end

        ST_RUN, ST_PEND: begin
          r_cnt  <= w_cnt_nxt;
          r_clko <= (w_cnt_nxt < w_half);
          r_ce   <= w_wrap;
          // A capture landing on the wrap edge itself still wins over the older pending value.
          if ((r_state == ST_PEND) && w_wrap) begin
            r_n   <= w_cap ? w_cap_val : r_pend;
            r_ack <= 1'b1;
          end
          if (w_wrap && !bus.en) begin
            r_state   <= ST_STOPPED;
            r_cnt     <= '0;
            r_clko    <= 1'b0;
            r_running <= 1'b0;
          end else if ((r_state == ST_PEND) && w_wrap) begin
            r_state <= ST_RUN;
          end else if (w_cap) begin
            r_state <= ST_PEND;
          end
        end

        default: begin
          r_state <= ST_STOPPED;
          r_cnt   <= '0;
          r_clko  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack     = r_ack;
  assign bus.clko    = r_clko;
  assign bus.ce      = r_ce;
  assign bus.running = r_running;

endmodule

// File: tb/tb_osc_clk_div.sv
// Scoreboard bench for osc_clk_div: expected {clko,ce,ack,running} per edge are queued
// from the stimulus plan and popped as each edge's outputs settle.
module tb_osc_clk_div;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rstn;

  osc_clk_div_if #(.WIDTH(WIDTH)) bus ();

  osc_clk_div #(.WIDTH(WIDTH), .DEF_DIV(4)) dut (
    .i_clki (clk),
    .i_rstn (rstn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #25 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [3:0] sb[$];
  logic [3:0] exp_v;
  logic [3:0] obs_v;

  function automatic logic [3:0] obs_now();
    return {bus.clko, bus.ce, bus.ack, bus.running};
  endfunction

  // One full CLKO period of ratio n; ce0/ack0 mark the strobes in its first cycle.
  task automatic push_per(input int n, input bit ce0, input bit ack0);
    for (int k = 0; k < n; k++) begin
      sb.push_back({(k < (n - n / 2)), ((k == 0) && ce0), ((k == 0) && ack0), 1'b1});
    end
  endtask

  task automatic apply_reset();
    rstn    = 1'b0;
    bus.en  = 1'b0;
    bus.req = 1'b0;
    bus.div = 8'd4;
    sb.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn    = 1'b0;
    bus.en  = 1'b1;
    bus.req = 1'b0;
    bus.div = 8'd4;
    sb.delete();
    sb.push_back(4'b0000);
    #1;
    exp_v = sb.pop_front();
    obs_v = obs_now();
    n_cmp++;
    if (obs_v !== exp_v) begin
      $display("FAIL reset_async: got %b need %b", obs_v, exp_v);
      n_fail++;
    end
    sb.push_back(4'b0000);
    sb.push_back(4'b0000);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 1) begin
        rstn   = 1'b1;
        bus.en = 1'b0;
      end
      @(posedge clk);
      #1;
      exp_v = sb.pop_front();
      obs_v = obs_now();
      n_cmp++;
      if (obs_v !== exp_v) begin
        $display("FAIL reset_idle edge %0d: got %b need %b", i, obs_v, exp_v);
        n_fail++;
      end
    end
  endtask

  task automatic test_basic();
    apply_reset();
    push_per(4, 1'b0, 1'b0);
    push_per(4, 1'b1, 1'b0);
    push_per(4, 1'b1, 1'b0);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 0) bus.en = 1'b1;
      @(posedge clk);
      #1;
      exp_v = sb.pop_front();
      obs_v = obs_now();
      n_cmp++;
      if (obs_v !== exp_v) begin
        $display("FAIL basic edge %0d: got clko/ce/ack/run=%b need %b", i, obs_v, exp_v);
        n_fail++;
      end
    end
  endtask

  task automatic test_ratio_change();
    apply_reset();
    push_per(4, 1'b0, 1'b0);
    push_per(4, 1'b1, 1'b0);
    push_per(5, 1'b1, 1'b1);
    push_per(5, 1'b1, 1'b0);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 0) bus.en = 1'b1;
      if (i == 5) begin
        bus.div = 8'd5;
        bus.req = 1'b1;
      end
      if (i == 6) bus.req = 1'b0;
      @(posedge clk);
      #1;
      exp_v = sb.pop_front();
      obs_v = obs_now();
      n_cmp++;
      if (obs_v !== exp_v) begin
        $display("FAIL ratio5 edge %0d: got clko/ce/ack/run=%b need %b", i, obs_v, exp_v);
        n_fail++;
      end
    end
  endtask

  task automatic test_div_min();
    apply_reset();
    push_per(4, 1'b0, 1'b0);
    push_per(2, 1'b1, 1'b1);
    for (int p = 0; p < 3; p++) push_per(2, 1'b1, 1'b0);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 0) bus.en = 1'b1;
      if (i == 1) begin
        bus.div = 8'd1;
        bus.req = 1'b1;
      end
      if (i == 2) bus.req = 1'b0;
      @(posedge clk);
      #1;
      exp_v = sb.pop_front();
      obs_v = obs_now();
      n_cmp++;
      if (obs_v !== exp_v) begin
        $display("FAIL div_min edge %0d: got clko/ce/ack/run=%b need %b", i, obs_v, exp_v);
        n_fail++;
      end
    end
  endtask

  task automatic test_double_req();
    apply_reset();
    push_per(4, 1'b0, 1'b0);
    push_per(3, 1'b1, 1'b1);
    push_per(3, 1'b1, 1'b0);
    push_per(3, 1'b1, 1'b0);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 0) bus.en = 1'b1;
      if (i == 1) begin
        bus.div = 8'd6;
        bus.req = 1'b1;
      end
      if (i == 2) bus.req = 1'b0;
      if (i == 3) begin
        bus.div = 8'd3;
        bus.req = 1'b1;
      end
      if (i == 4) bus.req = 1'b0;
      @(posedge clk);
      #1;
      exp_v = sb.pop_front();
      obs_v = obs_now();
      n_cmp++;
      if (obs_v !== exp_v) begin
        $display("FAIL double_req edge %0d: got clko/ce/ack/run=%b need %b", i, obs_v, exp_v);
        n_fail++;
      end
    end
  endtask

  // Captures landing exactly on wrap edges: deferred in RUN, overriding in PEND.
  task automatic test_back_to_back();
    apply_reset();
    push_per(4, 1'b0, 1'b0);
    push_per(4, 1'b1, 1'b0);
    push_per(3, 1'b1, 1'b1);
    push_per(2, 1'b1, 1'b1);
    push_per(2, 1'b1, 1'b0);
    push_per(2, 1'b1, 1'b0);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 0) bus.en = 1'b1;
      if (i == 4) begin
        bus.div = 8'd3;
        bus.req = 1'b1;
      end
      if (i == 5) bus.req = 1'b0;
      if (i == 9) begin
        bus.div = 8'd5;
        bus.req = 1'b1;
      end
      if (i == 10) bus.req = 1'b0;
      if (i == 11) begin
        bus.div = 8'd2;
        bus.req = 1'b1;
      end
      if (i == 12) bus.req = 1'b0;
      @(posedge clk);
      #1;
      exp_v = sb.pop_front();
      obs_v = obs_now();
      n_cmp++;
      if (obs_v !== exp_v) begin
        $display("FAIL back_to_back edge %0d: got clko/ce/ack/run=%b need %b", i, obs_v, exp_v);
        n_fail++;
      end
    end
  endtask

  task automatic test_stop();
    apply_reset();
    push_per(4, 1'b0, 1'b0);
    push_per(4, 1'b1, 1'b0);
    sb.push_back(4'b0100);
    sb.push_back(4'b0000);
    sb.push_back(4'b0010);
    push_per(8, 1'b0, 1'b0);
    push_per(8, 1'b1, 1'b0);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 0) bus.en = 1'b1;
      if (i == 5) bus.en = 1'b0;
      if (i == 10) begin
        bus.div = 8'd8;
        bus.req = 1'b1;
      end
      if (i == 11) begin
        bus.req = 1'b0;
        bus.en  = 1'b1;
      end
      @(posedge clk);
      #1;
      exp_v = sb.pop_front();
      obs_v = obs_now();
      n_cmp++;
      if (obs_v !== exp_v) begin
        $display("FAIL stop edge %0d: got clko/ce/ack/run=%b need %b", i, obs_v, exp_v);
        n_fail++;
      end
    end
  endtask

  task automatic test_reset_pend();
    apply_reset();
    sb.push_back(4'b1001);
    sb.push_back(4'b1001);
    sb.push_back(4'b0001);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 0) bus.en = 1'b1;
      if (i == 1) begin
        bus.div = 8'd7;
        bus.req = 1'b1;
      end
      if (i == 2) bus.req = 1'b0;
      @(posedge clk);
      #1;
      exp_v = sb.pop_front();
      obs_v = obs_now();
      n_cmp++;
      if (obs_v !== exp_v) begin
        $display("FAIL pend_pre edge %0d: got clko/ce/ack/run=%b need %b", i, obs_v, exp_v);
        n_fail++;
      end
    end
    #5;
    rstn = 1'b0;
    sb.push_back(4'b0000);
    #1;
    exp_v = sb.pop_front();
    obs_v = obs_now();
    n_cmp++;
    if (obs_v !== exp_v) begin
      $display("FAIL pend_async_rst: got %b need %b", obs_v, exp_v);
      n_fail++;
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    push_per(4, 1'b0, 1'b0);
    push_per(4, 1'b1, 1'b0);
    push_per(4, 1'b1, 1'b0);
    for (int i = 0; sb.size() > 0; i++) begin
      @(posedge clk);
      #1;
      exp_v = sb.pop_front();
      obs_v = obs_now();
      n_cmp++;
      if (obs_v !== exp_v) begin
        $display("FAIL pend_post edge %0d: got clko/ce/ack/run=%b need %b", i, obs_v, exp_v);
        n_fail++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ratio_change();
    test_div_min();
    test_double_req();
    test_back_to_back();
    test_stop();
    test_reset_pend();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: run did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
